// File: rtl/square_float.sv
// Sequential IEEE-754 single-precision squarer using a 24-cycle shift-add mantissa multiplier.
// Define ROUND_NEAREST_EN for round-to-nearest-even in NORM; the default build truncates.
module square_float #(
    parameter int NUM_ITER = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] u,
    output logic [31:0] out,
    output logic        done,
    output logic        ovf_flag,
    output logic        nan_flag
);

    typedef enum logic [2:0] {IDLE, LOAD, ITER, NORM, DONE} state_t;

    state_t      state;
    logic [30:0] u_reg;
    logic [23:0] mant;
    logic [4:0]  count;
    logic [47:0] acc;

    logic [9:0]  er_raw;
    logic [9:0]  er_fin;
    logic [22:0] frac_trunc;
    logic [22:0] frac_fin;
    logic        er_ovf;
    logic        er_unf;
`ifdef ROUND_NEAREST_EN
    logic        guard;
    logic        sticky;
    logic [23:0] rounded;
`else
    logic [21:0] unused_low;
`endif

    // Normaliser: the product of two 1.x mantissas lies in [1,4), so P[47] selects the shift.
    always_comb begin
        er_raw = {1'b0, u_reg[30:23], 1'b0} - 10'd127 + {9'd0, acc[47]};
        frac_trunc = acc[47] ? acc[46:24] : acc[45:23];
`ifdef ROUND_NEAREST_EN
        guard   = acc[47] ? acc[23] : acc[22];
        sticky  = acc[47] ? (|acc[22:0]) : (|acc[21:0]);
        rounded = {1'b0, frac_trunc} + {23'd0, guard & (sticky | frac_trunc[0])};
        frac_fin = rounded[22:0];
        er_fin   = er_raw + {9'd0, rounded[23]};
`else
        unused_low = acc[21:0];
        frac_fin   = frac_trunc;
        er_fin     = er_raw;
`endif
        er_ovf = $signed(er_fin) >= $signed(10'sd255);
        er_unf = $signed(er_fin) <= $signed(10'sd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            u_reg    <= '0;
            mant     <= '0;
            count    <= '0;
            acc      <= '0;
            out      <= '0;
            done     <= 1'b0;
            ovf_flag <= 1'b0;
            nan_flag <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        u_reg    <= u[30:0];
                        ovf_flag <= 1'b0;
                        nan_flag <= 1'b0;
                        state    <= LOAD;
                    end else begin
                        state <= IDLE;
                    end
                end
                LOAD: begin
                    // Sign is dropped: a square is never negative.
                    if (u_reg[30:23] == 8'd0) begin
                        out   <= 32'h0000_0000;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (u_reg[30:23] == 8'hFF) begin
                        if (u_reg[22:0] != 23'd0) begin
                            out      <= 32'h7FC0_0000;
                            nan_flag <= 1'b1;
                        end else begin
                            out <= 32'h7F80_0000;
                        end
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        mant  <= {1'b1, u_reg[22:0]};
                        acc   <= '0;
                        count <= '0;
                        state <= ITER;
                    end
                end
                ITER: begin
                    if (mant[count])
                        acc <= acc + ({24'd0, mant} << count);
                    count <= count + 5'd1;
                    if (count == 5'(NUM_ITER - 1))
                        state <= NORM;
                end
                NORM: begin
                    if (er_ovf) begin
                        out      <= 32'h7F80_0000;
                        ovf_flag <= 1'b1;
                    end else if (er_unf) begin
                        out <= 32'h0000_0000;
                    end else begin
                        out <= {1'b0, er_fin[7:0], frac_fin};
                    end
                    done  <= 1'b1;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_square_float.sv
// Scoreboard-driven testbench for square_float; honours ROUND_NEAREST_EN when defined.
module tb_square_float;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] u;
    logic [31:0] out;
    logic        done;
    logic        ovf_flag;
    logic        nan_flag;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        nan;
        int          lat;
    } exp_t;

    exp_t sb[$];

    square_float #(.NUM_ITER(24)) dut (
        .clk(clk), .rst(rst), .start(start), .u(u),
        .out(out), .done(done), .ovf_flag(ovf_flag), .nan_flag(nan_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Independent reference: full-width product, remainder-vs-half rounding.
    function automatic exp_t model(input logic [31:0] a);
        exp_t        r;
        logic [7:0]  e;
        logic [22:0] f;
        logic [47:0] p;
        logic [47:0] tmp;
        logic [23:0] frac;
        int          shift;
        int          er;
`ifdef ROUND_NEAREST_EN
        logic [47:0] rem;
        logic [47:0] half;
`endif
        r.res = 32'h0; r.ovf = 1'b0; r.nan = 1'b0; r.lat = 26;
        e = a[30:23];
        f = a[22:0];
        if (e == 8'd0) begin
            r.lat = 1;
            return r;
        end
        if (e == 8'hFF) begin
            r.lat = 1;
            if (f != 23'd0) begin
                r.res = 32'h7FC0_0000;
                r.nan = 1'b1;
            end else begin
                r.res = 32'h7F80_0000;
            end
            return r;
        end
        p = {24'd0, 1'b1, f} * {24'd0, 1'b1, f};
        shift = p[47] ? 24 : 23;
        er = 2 * int'(e) - 127 + (p[47] ? 1 : 0);
        tmp = p >> shift;
        frac = {1'b0, tmp[22:0]};
`ifdef ROUND_NEAREST_EN
        rem = p & ((48'd1 << shift) - 48'd1);
        half = 48'd1 << (shift - 1);
        if (rem > half || (rem == half && frac[0]))
            frac = frac + 24'd1;
        if (frac[23]) begin
            frac = 24'd0;
            er = er + 1;
        end
`endif
        if (er >= 255) begin
            r.res = 32'h7F80_0000;
            r.ovf = 1'b1;
        end else if (er <= 0) begin
            r.res = 32'h0;
        end else begin
            r.res = {1'b0, 8'(er), frac[22:0]};
        end
        return r;
    endfunction

    task automatic issue(input logic [31:0] val, output int lat, output logic timed_out);
        @(negedge clk);
        u = val;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        timed_out = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b0;
        u = 32'h0;
        #1;
        checks++;
        if (out !== 32'h0 || done !== 1'b0 || ovf_flag !== 1'b0 || nan_flag !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got out=%h done=%b ovf=%b nan=%b, want all zero",
                     out, done, ovf_flag, nan_flag);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_arith();
        logic [31:0] ops[8];
        logic [31:0] exps[8];
        int lat;
        logic to;
        exp_t e;
        ops  = '{32'h4040_0000, 32'hC000_0000, 32'h3F80_0000, 32'h3F80_0801,
                 32'h2000_0000, 32'h1F80_0000, 32'h5F7F_FFFF, 32'h5F80_0000};
`ifdef ROUND_NEAREST_EN
        exps = '{32'h4110_0000, 32'h4080_0000, 32'h3F80_0000, 32'h3F80_1003,
                 32'h0080_0000, 32'h0000_0000, 32'h7F7F_FFFE, 32'h7F80_0000};
`else
        exps = '{32'h4110_0000, 32'h4080_0000, 32'h3F80_0000, 32'h3F80_1002,
                 32'h0080_0000, 32'h0000_0000, 32'h7F7F_FFFE, 32'h7F80_0000};
`endif
        for (int i = 0; i < 8; i++) begin
            sb.push_back('{exps[i], (i == 7), 1'b0, 26});
            issue(ops[i], lat, to);
            e = sb.pop_front();
            checks++;
            if (to || lat !== e.lat) begin
                failures++;
                $display("FAIL arith_latency[%h]: got %0d timeout=%b, want %0d", ops[i], lat, to, e.lat);
            end
            checks++;
            if (out !== e.res) begin
                failures++;
                $display("FAIL arith_out[%h]: got %h, want %h", ops[i], out, e.res);
            end
            checks++;
            if (ovf_flag !== e.ovf || nan_flag !== e.nan) begin
                failures++;
                $display("FAIL arith_flags[%h]: got ovf=%b nan=%b, want ovf=%b nan=%b",
                         ops[i], ovf_flag, nan_flag, e.ovf, e.nan);
            end
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL arith_done_pulse[%h]: done=%b one cycle later, want 0", ops[i], done);
            end
        end
    endtask

    task automatic test_special();
        logic [31:0] ops[5];
        int lat;
        logic to;
        exp_t e;
        ops = '{32'h7FC0_0001, 32'h0000_0001, 32'h7F80_0000, 32'hFF80_0000, 32'h8000_0000};
        sb.push_back('{32'h7FC0_0000, 1'b0, 1'b1, 1});
        sb.push_back('{32'h0000_0000, 1'b0, 1'b0, 1});
        sb.push_back('{32'h7F80_0000, 1'b0, 1'b0, 1});
        sb.push_back('{32'h7F80_0000, 1'b0, 1'b0, 1});
        sb.push_back('{32'h0000_0000, 1'b0, 1'b0, 1});
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], lat, to);
            e = sb.pop_front();
            checks++;
            if (to || lat !== e.lat) begin
                failures++;
                $display("FAIL special_latency[%h]: got %0d timeout=%b, want %0d", ops[i], lat, to, e.lat);
            end
            checks++;
            if (out !== e.res) begin
                failures++;
                $display("FAIL special_out[%h]: got %h, want %h", ops[i], out, e.res);
            end
            checks++;
            if (ovf_flag !== e.ovf || nan_flag !== e.nan) begin
                failures++;
                $display("FAIL special_flags[%h]: got ovf=%b nan=%b, want ovf=%b nan=%b",
                         ops[i], ovf_flag, nan_flag, e.ovf, e.nan);
            end
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL special_done_pulse[%h]: done=%b one cycle later, want 0", ops[i], done);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] op;
        int lat;
        logic to;
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            op = $urandom;
            if (i < 6)
                op[30:23] = 8'($urandom_range(100, 160));
            sb.push_back(model(op));
            issue(op, lat, to);
            e = sb.pop_front();
            checks++;
            if (to || lat !== e.lat) begin
                failures++;
                $display("FAIL random_latency[%h]: got %0d timeout=%b, want %0d", op, lat, to, e.lat);
            end
            checks++;
            if (out !== e.res || ovf_flag !== e.ovf || nan_flag !== e.nan) begin
                failures++;
                $display("FAIL random_result[%h]: got %h ovf=%b nan=%b, want %h ovf=%b nan=%b",
                         op, out, ovf_flag, nan_flag, e.res, e.ovf, e.nan);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic to;
        exp_t e;
        sb.push_back('{32'h7F80_0000, 1'b1, 1'b0, 26});
        sb.push_back('{32'h4110_0000, 1'b0, 1'b0, 26});
        issue(32'h7F00_0000, lat, to);
        e = sb.pop_front();
        checks++;
        if (to || out !== e.res || ovf_flag !== e.ovf) begin
            failures++;
            $display("FAIL b2b_first: got %h ovf=%b timeout=%b, want %h ovf=%b", out, ovf_flag, to, e.res, e.ovf);
        end
        u = 32'h4040_0000;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        checks++;
        if (done !== 1'b0 || ovf_flag !== 1'b0 || out !== 32'h7F80_0000) begin
            failures++;
            $display("FAIL b2b_accept: got done=%b ovf=%b out=%h, want done=0 ovf=0 out=7f800000",
                     done, ovf_flag, out);
        end
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat || out !== e.res || ovf_flag !== e.ovf) begin
            failures++;
            $display("FAIL b2b_second: got lat=%0d out=%h ovf=%b, want lat=%0d out=%h ovf=%b",
                     lat, out, ovf_flag, e.lat, e.res, e.ovf);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_ignore_start();
        int lat;
        @(negedge clk);
        u = 32'h4040_0000;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i == 5) begin
                u = 32'h3F80_0000;
                start = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat !== 26 || out !== 32'h4110_0000) begin
            failures++;
            $display("FAIL ignore_start: got lat=%0d out=%h, want lat=26 out=41100000", lat, out);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_abort();
        int lat;
        logic to;
        logic seen;
        @(negedge clk);
        u = 32'h4040_0000;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (out !== 32'h0 || done !== 1'b0 || ovf_flag !== 1'b0 || nan_flag !== 1'b0) begin
            failures++;
            $display("FAIL abort_async: got out=%h done=%b ovf=%b nan=%b, want all zero",
                     out, done, ovf_flag, nan_flag);
        end
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_done: got done pulse after abort, want none");
        end
        sb.push_back('{32'h4080_0000, 1'b0, 1'b0, 26});
        issue(32'h4000_0000, lat, to);
        checks++;
        if (to || lat !== sb[0].lat || out !== sb[0].res) begin
            failures++;
            $display("FAIL abort_restart: got lat=%0d out=%h timeout=%b, want lat=%0d out=%h",
                     lat, out, to, sb[0].lat, sb[0].res);
        end
        void'(sb.pop_front());
    endtask

    initial begin
        test_reset();
        test_arith();
        test_special();
        test_random();
        test_back_to_back();
        test_ignore_start();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/square_float.md
# square_float

Sequential IEEE-754 single-precision squarer, the inverse operation of the CORDIC square-root unit in the float CORDIC library. It squares an input operand with a 24-bit iterative shift-add mantissa multiplier, one multiplier bit per cycle. It is used to check and re-expand square-root results (sqrt(x)² ≈ x) and feeds the same start/done handshake fabric. Control is a small FSM; the datapath is an operand register, a multiplier counter, a 48-bit accumulator and a normaliser.

## Interface
- NUM_ITER, 24: multiplier iterations. Fixed at 24 for full single-precision mantissa; other values are unsupported.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request. Sampled only in IDLE or DONE.
- u  input  32  operand. Captured on the edge that accepts start.
- out  output  32  result. Registered; holds its value until the next result is written.
- done  output  1  high for exactly one cycle while the FSM is in DONE.
- ovf_flag  output  1  set with a result that overflowed to +inf; cleared when the next start is accepted.
- nan_flag  output  1  set with a NaN result; cleared when the next start is accepted.

## Operation
- FSM states: IDLE, LOAD, ITER, NORM, DONE.
- IDLE/DONE: start=1 → LOAD, register u. Otherwise DONE → IDLE.
- LOAD: unpack and classify the operand. The sign bit is ignored, since the result sign is always 0.
  - Exponent 0 (zero or denormal; denormals are flushed): out=0x00000000 → DONE.
  - Exponent 255 with fraction ≠ 0: out=0x7FC00000, nan_flag=1 → DONE.
  - Exponent 255 with fraction 0: out=0x7F800000 → DONE. ovf_flag stays 0.
  - Otherwise: M={1,frac} (24 bits), acc=0, counter=0 → ITER.
- ITER: each cycle add M·2^i to the 48-bit accumulator when multiplier bit i is 1, LSB first. The counter increments each cycle. After counter reaches 23, the next state is NORM, and acc=M·M exactly.
- NORM:
  - Intermediate exponent er = 2·e − 127 + P[47], 10-bit signed.
  - If P[47]=1, fraction = P[46:24]; else fraction = P[45:23].
  - Without rounding, the remaining low bits are discarded (truncation).
  - If er ≥ 255: out=0x7F800000, ovf_flag=1.
  - If er ≤ 0: out=0x00000000 (underflow flushes to zero, no flag).
  - Otherwise out = {1'b0, er[7:0], fraction}.
- start while in LOAD/ITER/NORM is ignored; no queueing.
- Reset at any point: state IDLE, out=0, done=0, ovf_flag=0, nan_flag=0, counter=0. Any in-flight operation is aborted.

## Timing
- Let the start-accepting edge be edge k.
- Normal path:
  - LOAD at k.
  - ITER entered at k+1; iterations occur on edges k+2..k+25.
  - NORM at k+25.
  - DONE and out written at k+26.
  - done is high between edges k+26 and k+27.
- Special-case path: DONE and out written at k+1. done is high between k+1 and k+2.
- Back-to-back operation: start high during DONE is accepted, so the next LOAD follows immediately. done still pulses for exactly one cycle.
- out, ovf_flag and nan_flag change only on DONE entry. Both flags also clear on start acceptance.

## Configuration
- ROUND_NEAREST_EN defined: NORM applies round-to-nearest-even.
  - Guard bit = first discarded bit; sticky = OR of all lower discarded bits.
  - Round up if guard & (sticky | fraction LSB).
  - A mantissa carry-out sets fraction=0 and er+1, and the overflow check is made after rounding.
  - Adds one adder stage inside NORM; latency is unchanged.
- Not defined: the discarded bits are truncated.

## Test plan
- u=0x40400000 (3.0), start at edge k → out=0x41100000 (9.0) and done high after edge k+26, for exactly one cycle.
- u=0xC0000000 (−2.0) → out=0x40800000.
- u=0x3F800000 (1.0) → out=0x3F800000.
- u=0x7F000000 → out=0x7F800000, ovf_flag=1.
- u=0x7FC00001 → out=0x7FC00000, nan_flag=1, done after edge k+1.
- u=0x00000001 (denormal) → out=0x00000000.
- u=0x3F800801 → out=0x3F801002 without ROUND_NEAREST_EN; out=0x3F801003 with it.
- Start 3.0, pulse start again during ITER, then assert rst low at edge k+10:
  - The extra start is ignored.
  - Outputs return to 0 asynchronously and no done pulse occurs.
  - A subsequent start with u=0x40000000 → out=0x40800000 at k'+26.
